instruction_fetch: RTL and testbench
====================================

// Module: instruction_fetch
// PURPOSE
//  Stage-1 fetch: owns the PC, drives the I-cache read port, fills the IF/ID register (instruction_1, PC_1).
//  Consumes ID-stage redirect and hazard controls (branch_address, PC_src, IF_flush, PC_write, IF_DWrite).
//  A one-entry fetch buffer keeps a returned word while the pipeline is frozen or holding.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC value loaded on reset
//  NOP_INSTR  32'h0000_0013  bubble inserted on flush/reset (addi x0,x0,0)
// PORTS
//  clk            in   1   single clock, all state on posedge
//  rst            in   1   synchronous reset, active-high
//  memory_stall   in   1   global freeze (OR of I/D-cache stalls, built at top)
//  PC_src         in   1   1: redirect to branch_address
//  IF_flush       in   1   1: squash IF/ID to NOP on redirect
//  PC_write       in   1   1: hazard hold (PC and IF/ID re-load IF_DWrite)
//  branch_address in   32  redirect target from ID
//  IF_DWrite      in   32  instruction re-fed to IF/ID during hazard hold
//  ICACHE_rdata   in   32  I-cache read data, valid when ICACHE_stall==0
//  ICACHE_stall   in   1   1: I-cache has not returned the requested word
//  ICACHE_ren     out  1   read request
//  ICACHE_addr    out  30  word address = PC_r[31:2]
//  instruction_1  out  32  IF/ID instruction
//  PC_1           out  32  IF/ID PC of instruction_1
// BEHAVIOUR
//  Reset (rst=1 at posedge): PC_r=RESET_PC, instruction_1=NOP_INSTR, PC_1=RESET_PC, buffer empty,
//   state=FETCH. Applies mid-fetch; any outstanding cache reply afterwards is ignored until re-request.
//  States: FETCH (ICACHE_ren=1, buf empty); HOLD (ICACHE_ren=0, buf_valid=1, buf holds word at PC_r).
//  word_avail = buf_valid | (ICACHE_ren & ~ICACHE_stall); word = buf_valid ? buf : ICACHE_rdata.
//  Per-cycle priority (rst excluded):
//   1 memory_stall=1: PC_r, IF/ID held. If FETCH and ICACHE_stall=0 -> capture rdata in buf, go HOLD.
//   2 PC_write=1: PC_r held; instruction_1<=IF_DWrite; PC_1 held. word_avail -> buffer it (HOLD).
//     PC_src/IF_flush ignored this cycle (target built from stale operands; ID re-asserts next cycle).
//   3 PC_src=1: PC_r<={branch_address[31:2],2'b00}; buf cleared, state FETCH;
//     IF_flush=1 -> instruction_1<=NOP_INSTR, PC_1<=PC_r; IF_flush=0 -> IF/ID held.
//     Word fetched at old PC is discarded.
//   4 else (word_avail guaranteed, cache miss shows as memory_stall): instruction_1<=word,
//     PC_1<=PC_r, PC_r<=PC_r+4 (mod 2^32, wraps 32'hFFFF_FFFC->0), buf cleared, state FETCH.
//  ICACHE_addr stable whenever ICACHE_ren=1 and ICACHE_stall=1 (protocol rule for the cache).
//  Zero bubble on sequential flow: one instruction per non-stalled cycle. Redirect penalty: 1 NOP.
//  Outputs are registered except ICACHE_ren/ICACHE_addr (decoded from state and PC_r).
// STRUCTURE
//  pipeline_pkg: NOP_INSTR, RESET_PC, fetch state encoding (FETCH/HOLD), opcode constants shared with ID.
//  Sub-module fetch_buffer: one-entry 32-bit word + valid; load/clear ports. PC/FSM/IF-ID stay top-level.
// TESTING
//  Reset then 3 sequential hits (stall=0) -> ICACHE_addr 0,1,2; PC_1 0,4,8; ren=1 throughout.
//  ICACHE_stall=1 for 4 cycles at PC=0x10 -> addr held 0x4, IF/ID held; then word at PC_1=0x10.
//  Data-side stall (memory_stall=1, ICACHE_stall=0) 3 cycles -> ren drops after 1 cycle, buffered word
//   issued on release without re-fetch.
//  PC_src=1, IF_flush=1, branch_address=0x40 at PC=0x20 -> instruction_1=0x13, next addr 0x10, PC_1=0x40 after.
//  PC_write=1 together with PC_src=1 -> PC unchanged, instruction_1==IF_DWrite; redirect taken next cycle.
//  PC_r=0xFFFF_FFFC sequential -> next PC 0x0; rst asserted during I-cache miss -> PC=0, instruction_1=0x13.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared pipeline constants: reset/bubble values, fetch FSM encoding and
// the base opcodes that the decode stage also keys on.
package pipeline_pkg;

  localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;  // addi x0,x0,0

  typedef enum logic {
    FETCH = 1'b0,  // request outstanding to the I-cache, buffer empty
    HOLD  = 1'b1   // word at PC_r parked in the fetch buffer, no request
  } fetch_state_e;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

endpackage

// File: rtl/fetch_buffer.sv
// One-entry word buffer with valid flag; clear takes priority over load.
module fetch_buffer #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              clear,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              valid
);

  // Valid flag is control state and is reset; the data word is not.
  always_ff @(posedge clk) begin
    if (rst)        valid <= 1'b0;
    else if (clear) valid <= 1'b0;
    else if (load)  valid <= 1'b1;
  end

  // Capture the word whenever a load is requested.
  always_ff @(posedge clk) begin
    if (load && !clear) dout <= din;
  end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, drives the I-cache read port and fills IF/ID.
// A one-entry buffer parks a returned word while the pipeline is frozen or
// holding, so the word is never requested twice.
module instruction_fetch
  import pipeline_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memory_stall,
  input  logic        PC_src,
  input  logic        IF_flush,
  input  logic        PC_write,
  input  logic [31:0] branch_address,
  input  logic [31:0] IF_DWrite,
  input  logic [31:0] ICACHE_rdata,
  input  logic        ICACHE_stall,
  output logic        ICACHE_ren,
  output logic [29:0] ICACHE_addr,
  output logic [31:0] instruction_1,
  output logic [31:0] PC_1
);

  fetch_state_e state, state_next;
  logic [31:0]  pc_r, pc_d, instr_d, pc1_d;
  logic [31:0]  buf_word, word;
  logic         buf_valid, buf_load, buf_clear, word_avail;

  // Redirect targets are word aligned; the low target bits are dropped.
  logic unused_target_lsbs;
  assign unused_target_lsbs = ^branch_address[1:0];

  fetch_buffer #(.DATA_W(32)) u_fetch_buffer (
    .clk   (clk),
    .rst   (rst),
    .load  (buf_load),
    .clear (buf_clear),
    .din   (word),
    .dout  (buf_word),
    .valid (buf_valid)
  );

  // Cache port is decoded from state so the address cannot move while a
  // request is pending: PC_r only changes when the word has been consumed.
  assign ICACHE_ren  = (state == FETCH);
  assign ICACHE_addr = pc_r[31:2];
  assign word_avail  = buf_valid | (ICACHE_ren & ~ICACHE_stall);
  assign word        = buf_valid ? buf_word : ICACHE_rdata;

  // Fetch state register.
  always_ff @(posedge clk) begin
    if (rst) state <= FETCH;
    else     state <= state_next;
  end

  // Next-state and datapath selection, in priority order:
  // freeze, hazard hold, redirect, sequential issue.
  always_comb begin
    state_next = state;
    buf_load   = 1'b0;
    buf_clear  = 1'b0;
    pc_d       = pc_r;
    instr_d    = instruction_1;
    pc1_d      = PC_1;
    if (memory_stall) begin
      if (state == FETCH && !ICACHE_stall) begin
        buf_load   = 1'b1;
        state_next = HOLD;
      end
    end else if (PC_write) begin
      // Redirect is ignored here: ID re-asserts it once operands are fresh.
      instr_d = IF_DWrite;
      if (word_avail) begin
        buf_load   = 1'b1;
        state_next = HOLD;
      end
    end else if (PC_src) begin
      pc_d       = {branch_address[31:2], 2'b00};
      buf_clear  = 1'b1;
      state_next = FETCH;
      if (IF_flush) begin
        instr_d = NOP_INSTR;
        pc1_d   = pc_r;
      end
    end else if (word_avail) begin
      instr_d    = word;
      pc1_d      = pc_r;
      pc_d       = pc_r + 32'd4;
      buf_clear  = 1'b1;
      state_next = FETCH;
    end
  end

  // ---- IF / ID boundary: PC and IF/ID register ----
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_r          <= RESET_PC;
      instruction_1 <= NOP_INSTR;
      PC_1          <= RESET_PC;
    end else begin
      pc_r          <= pc_d;
      instruction_1 <= instr_d;
      PC_1          <= pc1_d;
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch. The I-cache returns {2'b10, addr}
// for every word address, optionally corrupted to prove buffered reuse.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        memory_stall, PC_src, IF_flush, PC_write;
  logic [31:0] branch_address, IF_DWrite, ICACHE_rdata, rdata_xor;
  logic        ICACHE_stall, ICACHE_ren;
  logic [29:0] ICACHE_addr;
  logic [31:0] instruction_1, PC_1;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  assign ICACHE_rdata = {2'b10, ICACHE_addr} ^ rdata_xor;

  instruction_fetch dut (
    .clk            (clk),
    .rst            (rst),
    .memory_stall   (memory_stall),
    .PC_src         (PC_src),
    .IF_flush       (IF_flush),
    .PC_write       (PC_write),
    .branch_address (branch_address),
    .IF_DWrite      (IF_DWrite),
    .ICACHE_rdata   (ICACHE_rdata),
    .ICACHE_stall   (ICACHE_stall),
    .ICACHE_ren     (ICACHE_ren),
    .ICACHE_addr    (ICACHE_addr),
    .instruction_1  (instruction_1),
    .PC_1           (PC_1)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [31:0] e_addr, input logic [31:0] e_instr,
                         input logic [31:0] e_pc1, input logic e_ren);
    chk({tag, ".addr"},  {2'b00, ICACHE_addr}, e_addr);
    chk({tag, ".instr"}, instruction_1, e_instr);
    chk({tag, ".pc1"},   PC_1, e_pc1);
    chk({tag, ".ren"},   {31'b0, ICACHE_ren}, {31'b0, e_ren});
  endtask

  initial begin
    rst = 1'b1; memory_stall = 1'b0; PC_src = 1'b0; IF_flush = 1'b0; PC_write = 1'b0;
    branch_address = 32'h0; IF_DWrite = 32'h0; ICACHE_stall = 1'b0; rdata_xor = 32'h0;

    // Reset
    step();
    chk_all("reset", 32'h0, 32'h0000_0013, 32'h0, 1'b1);
    rst = 1'b0;

    // Sequential hits
    step(); chk_all("seq0", 32'h1, 32'h8000_0000, 32'h0, 1'b1);
    step(); chk_all("seq1", 32'h2, 32'h8000_0001, 32'h4, 1'b1);
    step(); chk_all("seq2", 32'h3, 32'h8000_0002, 32'h8, 1'b1);
    step(); chk_all("seq3", 32'h4, 32'h8000_0003, 32'hC, 1'b1);

    // I-cache miss at PC 0x10 for 4 cycles
    ICACHE_stall = 1'b1; memory_stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(); chk_all("imiss", 32'h4, 32'h8000_0003, 32'hC, 1'b1);
    end
    ICACHE_stall = 1'b0; memory_stall = 1'b0;
    step(); chk_all("imiss_done", 32'h5, 32'h8000_0004, 32'h10, 1'b1);

    // Data-side stall: word at 0x14 buffered, cache data then corrupted
    memory_stall = 1'b1;
    step(); chk_all("dstall0", 32'h5, 32'h8000_0004, 32'h10, 1'b0);
    rdata_xor = 32'hFFFF_FFFF;
    step(); chk_all("dstall1", 32'h5, 32'h8000_0004, 32'h10, 1'b0);
    step(); chk_all("dstall2", 32'h5, 32'h8000_0004, 32'h10, 1'b0);
    memory_stall = 1'b0;
    step(); chk_all("dstall_rel", 32'h6, 32'h8000_0005, 32'h14, 1'b1);
    rdata_xor = 32'h0;
    step(); chk_all("seq4", 32'h7, 32'h8000_0006, 32'h18, 1'b1);
    step(); chk_all("seq5", 32'h8, 32'h8000_0007, 32'h1C, 1'b1);

    // Flushed redirect at PC 0x20 to 0x40
    PC_src = 1'b1; IF_flush = 1'b1; branch_address = 32'h40;
    step(); chk_all("br_flush", 32'h10, 32'h0000_0013, 32'h20, 1'b1);
    PC_src = 1'b0; IF_flush = 1'b0;
    step(); chk_all("br_target", 32'h11, 32'h8000_0010, 32'h40, 1'b1);

    // Hazard hold with a concurrent redirect: hold wins, redirect next cycle
    PC_write = 1'b1; PC_src = 1'b1; IF_flush = 1'b1; branch_address = 32'h80;
    IF_DWrite = 32'hDEAD_BEEF;
    step(); chk_all("hold", 32'h11, 32'hDEAD_BEEF, 32'h40, 1'b0);
    PC_write = 1'b0;
    step(); chk_all("hold_br", 32'h20, 32'h0000_0013, 32'h44, 1'b1);
    PC_src = 1'b0; IF_flush = 1'b0;
    step(); chk_all("hold_tgt", 32'h21, 32'h8000_0020, 32'h80, 1'b1);

    // Unflushed redirect to top of memory (low bits masked), then wrap
    PC_src = 1'b1; branch_address = 32'hFFFF_FFFE;
    step(); chk_all("br_top", 32'h3FFF_FFFF, 32'h8000_0020, 32'h80, 1'b1);
    PC_src = 1'b0;
    step(); chk_all("wrap", 32'h0, 32'hBFFF_FFFF, 32'hFFFF_FFFC, 1'b1);
    step(); chk_all("wrap_seq", 32'h1, 32'h8000_0000, 32'h0, 1'b1);

    // Reset during an I-cache miss
    ICACHE_stall = 1'b1; memory_stall = 1'b1;
    step(); chk_all("miss_pre", 32'h1, 32'h8000_0000, 32'h0, 1'b1);
    rst = 1'b1;
    step(); chk_all("miss_rst", 32'h0, 32'h0000_0013, 32'h0, 1'b1);
    rst = 1'b0;
    step(); chk_all("miss_post", 32'h0, 32'h0000_0013, 32'h0, 1'b1);
    ICACHE_stall = 1'b0; memory_stall = 1'b0;
    step(); chk_all("miss_done", 32'h1, 32'h8000_0000, 32'h0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
